// File: rtl/axis_slave_packet_rx.sv
// AXI-Stream byte slave that packs PKT_BYTES-beat packets into one word with a valid/ready handoff.
// Optional XOR checksum on csum is built when AXIS_RX_CHECKSUM_EN is defined; otherwise csum is tied to 0.
module axis_slave_packet_rx #(
  parameter int DATA_W    = 8,
  parameter int PKT_BYTES = 4,
  parameter int CNT_W     = 16
) (
  input  logic                        s_axis_clk,
  input  logic                        s_axis_rst,
  input  logic                        s_axis_tvalid,
  input  logic [DATA_W-1:0]           s_axis_tdata,
  input  logic                        s_axis_tlast,
  output logic                        s_axis_tready,
  output logic [DATA_W*PKT_BYTES-1:0] dout,
  output logic                        dout_valid,
  input  logic                        dout_ready,
  output logic                        pkt_err,
  output logic [CNT_W-1:0]            pkt_count,
  output logic [DATA_W-1:0]           csum
);

  localparam int OUT_W = DATA_W * PKT_BYTES;
  localparam int IDX_W = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_BYTES - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, FULL, DRAIN} state_t;

  state_t            state;
  state_t            next_state;
  logic [IDX_W-1:0]  idx;
  logic [OUT_W-1:0]  word;
  logic              err_q;
  logic              drain_pend;
  logic [CNT_W-1:0]  count_q;
  logic              accept;
  logic              store;
  logic              at_last;
  logic              pkt_end;

  function automatic logic [OUT_W-1:0] insert_beat(input logic [OUT_W-1:0]  base,
                                                   input logic [IDX_W-1:0]  pos,
                                                   input logic [DATA_W-1:0] beat);
    logic [OUT_W-1:0] w;
    w = base;
    for (int k = 0; k < PKT_BYTES; k++) begin
      if (pos == IDX_W'(k)) w[k*DATA_W +: DATA_W] = beat;
    end
    return w;
  endfunction

  assign accept  = s_axis_tvalid && s_axis_tready;
  assign store   = accept && ((state == IDLE) || (state == COLLECT));
  assign at_last = (idx == LAST_IDX);
  assign pkt_end = store && (s_axis_tlast || at_last);

  // tready is registered from next_state so it is low for exactly the FULL cycles
  always_ff @(posedge s_axis_clk or posedge s_axis_rst) begin
    if (s_axis_rst) begin
      state         <= IDLE;
      s_axis_tready <= 1'b0;
    end else begin
      state         <= next_state;
      s_axis_tready <= (next_state != FULL);
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, COLLECT: begin
        if (pkt_end)    next_state = FULL;
        else if (store) next_state = COLLECT;
      end
      FULL: begin
        if (dout_ready) next_state = drain_pend ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (accept && s_axis_tlast) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    dout_valid = 1'b0;
    if (state == FULL) dout_valid = 1'b1;
  end

  // Packet-ending beat: long packets (no tlast at last slot) arm the drain of the remainder
  always_ff @(posedge s_axis_clk or posedge s_axis_rst) begin
    if (s_axis_rst) begin
      word       <= '0;
      idx        <= '0;
      err_q      <= 1'b0;
      drain_pend <= 1'b0;
      count_q    <= '0;
    end else begin
      if (store) begin
        word <= insert_beat((state == IDLE) ? OUT_W'(0) : word, idx, s_axis_tdata);
        if (pkt_end) begin
          idx        <= '0;
          err_q      <= !(s_axis_tlast && at_last);
          drain_pend <= !s_axis_tlast;
        end else begin
          idx   <= idx + IDX_W'(1);
          err_q <= 1'b0;
        end
      end else if (state == IDLE) begin
        word  <= '0;
        idx   <= '0;
        err_q <= 1'b0;
      end
      if (dout_valid && dout_ready) count_q <= count_q + CNT_W'(1);
      if ((state == DRAIN) && accept && s_axis_tlast) drain_pend <= 1'b0;
    end
  end

  assign dout      = word;
  assign pkt_err   = err_q;
  assign pkt_count = count_q;

`ifdef AXIS_RX_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;

  always_ff @(posedge s_axis_clk or posedge s_axis_rst) begin
    if (s_axis_rst) begin
      csum_q <= '0;
    end else if (store) begin
      csum_q <= ((state == IDLE) ? DATA_W'(0) : csum_q) ^ s_axis_tdata;
    end else if (state == IDLE) begin
      csum_q <= '0;
    end
  end

  assign csum = csum_q;
`else
  assign csum = '0;
`endif

endmodule

// File: tb/tb_axis_slave_packet_rx.sv
// Directed bench for axis_slave_packet_rx: packet table plus backpressure, reset and wrap sequences.
// The DUT runs with CNT_W=2 so pkt_count wrap is exercised.
module tb_axis_slave_packet_rx;

`ifdef AXIS_RX_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tvalid = 1'b0;
  logic [7:0]  tdata = 8'h00;
  logic        tlast = 1'b0;
  logic        tready;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_ready = 1'b1;
  logic        pkt_err;
  logic [1:0]  pkt_count;
  logic [7:0]  csum;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_count = 0;

  axis_slave_packet_rx #(.DATA_W(8), .PKT_BYTES(4), .CNT_W(2)) dut (
    .s_axis_clk   (clk),
    .s_axis_rst   (rst),
    .s_axis_tvalid(tvalid),
    .s_axis_tdata (tdata),
    .s_axis_tlast (tlast),
    .s_axis_tready(tready),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready),
    .pkt_err      (pkt_err),
    .pkt_count    (pkt_count),
    .csum         (csum)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          n;
    int          end_idx;
    logic [7:0]  b [6];
    logic [31:0] exp_dout;
    logic        exp_err;
    logic [7:0]  exp_csum;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_beat(input logic [7:0] d, input logic last);
    int   waits;
    logic took;
    tvalid = 1'b1;
    tdata  = d;
    tlast  = last;
    waits  = 0;
    do begin
      took = tready;
      @(posedge clk);
      #1;
      waits++;
    end while (!took && waits < 20);
    if (!took) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: beat %0h not accepted within %0d cycles", d, waits);
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic check_word(input string name, input logic [31:0] ed, input logic ee,
                            input logic [7:0] ec);
    chk({name, "_valid"}, dout_valid, 1'b1);
    chk({name, "_dout"}, dout, ed);
    chk({name, "_err"}, pkt_err, ee);
    chk({name, "_csum"}, csum, CSUM_EN ? ec : 8'h00);
  endtask

  initial begin
    int t_prev;
    vecs[0] = '{n:4, end_idx:3, b:'{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00},
                exp_dout:32'h44332211, exp_err:1'b0, exp_csum:8'h44};
    vecs[1] = '{n:2, end_idx:1, b:'{8'hAA, 8'hBB, 8'h00, 8'h00, 8'h00, 8'h00},
                exp_dout:32'h0000BBAA, exp_err:1'b1, exp_csum:8'h11};
    vecs[2] = '{n:6, end_idx:3, b:'{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06},
                exp_dout:32'h04030201, exp_err:1'b1, exp_csum:8'h04};
    vecs[3] = '{n:4, end_idx:3, b:'{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00},
                exp_dout:32'hEFBEADDE, exp_err:1'b0, exp_csum:8'h22};
    vecs[4] = '{n:1, end_idx:0, b:'{8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                exp_dout:32'h0000007F, exp_err:1'b1, exp_csum:8'h7F};
    vecs[5] = '{n:3, end_idx:2, b:'{8'h10, 8'h20, 8'h30, 8'h00, 8'h00, 8'h00},
                exp_dout:32'h00302010, exp_err:1'b1, exp_csum:8'h00};
    vecs[6] = '{n:4, end_idx:3, b:'{8'h01, 8'h02, 8'h04, 8'h08, 8'h00, 8'h00},
                exp_dout:32'h08040201, exp_err:1'b0, exp_csum:8'h0F};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tready", tready, 1'b0);
    chk("rst_dout", dout, 32'h0);
    chk("rst_valid", dout_valid, 1'b0);
    chk("rst_err", pkt_err, 1'b0);
    chk("rst_count", pkt_count, 2'd0);
    chk("rst_csum", csum, 8'h00);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("tready_after_rst", tready, 1'b1);

    // Packet table: good, short, long (drained), single-beat, three-beat
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < vecs[v].n; i++) begin
        send_beat(vecs[v].b[i], i == vecs[v].n - 1);
        if (i == vecs[v].end_idx) begin
          check_word($sformatf("vec%0d", v), vecs[v].exp_dout, vecs[v].exp_err, vecs[v].exp_csum);
          chk($sformatf("vec%0d_tready_full", v), tready, 1'b0);
          @(posedge clk);
          #1;
          exp_count = (exp_count + 1) % 4;
          chk($sformatf("vec%0d_count", v), pkt_count, exp_count);
          chk($sformatf("vec%0d_valid_drop", v), dout_valid, 1'b0);
        end
      end
      chk($sformatf("vec%0d_no_extra_word", v), dout_valid, 1'b0);
    end

    // Backpressure: word held for 5 cycles while the next beat waits upstream
    dout_ready = 1'b0;
    send_beat(8'h11, 1'b0);
    send_beat(8'h22, 1'b0);
    send_beat(8'h33, 1'b0);
    send_beat(8'h44, 1'b1);
    check_word("bp_first", 32'h44332211, 1'b0, 8'h44);
    tvalid = 1'b1;
    tdata  = 8'hAA;
    tlast  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp_hold%0d_valid", k), dout_valid, 1'b1);
      chk($sformatf("bp_hold%0d_dout", k), dout, 32'h44332211);
      chk($sformatf("bp_hold%0d_tready", k), tready, 1'b0);
    end
    chk("bp_count_held", pkt_count, exp_count);
    dout_ready = 1'b1;
    send_beat(8'hAA, 1'b0);
    exp_count = (exp_count + 1) % 4;
    chk("bp_count", pkt_count, exp_count);
    send_beat(8'hBB, 1'b0);
    send_beat(8'hCC, 1'b0);
    send_beat(8'hDD, 1'b1);
    check_word("bp_next", 32'hDDCCBBAA, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    exp_count = (exp_count + 1) % 4;
    chk("bp_next_count", pkt_count, exp_count);

    // Reset in the middle of a packet
    send_beat(8'h12, 1'b0);
    send_beat(8'h34, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_valid", dout_valid, 1'b0);
    chk("midrst_count", pkt_count, 2'd0);
    chk("midrst_tready", tready, 1'b0);
    chk("midrst_dout", dout, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_count = 0;
    send_beat(8'h55, 1'b0);
    send_beat(8'h66, 1'b0);
    send_beat(8'h77, 1'b0);
    send_beat(8'h88, 1'b1);
    check_word("postrst", 32'h88776655, 1'b0, 8'hCC);
    @(posedge clk);
    #1;
    chk("postrst_count", pkt_count, 2'd1);

    // Back-to-back packets: pkt_count wraps and one packet lands every 5 cycles
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    t_prev = 0;
    for (int p = 0; p < 5; p++) begin
      send_beat(8'h01, 1'b0);
      send_beat(8'h02, 1'b0);
      send_beat(8'h03, 1'b0);
      send_beat(8'h04, 1'b1);
      check_word($sformatf("b2b%0d", p), 32'h04030201, 1'b0, 8'h04);
      chk($sformatf("b2b%0d_count", p), pkt_count, p % 4);
      if (p > 0) chk($sformatf("b2b%0d_period", p), cyc - t_prev, 5);
      t_prev = cyc;
    end
    @(posedge clk);
    #1;
    chk("b2b_final_count", pkt_count, 2'd1);
    chk("b2b_final_valid", dout_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
